fetch_debug_ctrl: RTL and testbench

Controller that sequences the MIPS fetch stage and pipeline. It receives a program as a byte stream and assembles it into 32-bit words. It writes those words into instruction memory, then runs the pipeline continuously or one cycle at a time. When the halt word is fetched, it freezes the PC, lets the pipeline drain, and reports completion. It sits between the UART receiver and the fetch stage, and owns the memory write port, pipeline enable and pipeline reset.

---
 rtl/fetch_debug_pkg.sv | 28 ++
 rtl/fetch_debug_ctrl_if.sv | 38 +++
 rtl/fetch_debug_ctrl_byte_word_assembler.sv | 42 ++++
 rtl/fetch_debug_ctrl.sv | 174 +++++++++++++++++
 tb/tb_fetch_debug_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_debug_pkg.sv
// Shared encodings for the fetch/debug controller: states, command bytes,
// bus widths and the default halt instruction.
`timescale 1ns/1ps
package fetch_debug_pkg;

    localparam int LEN    = 32;
    localparam int ADDR_W = 11;

    localparam logic [LEN-1:0] HALT_WORD_DEFAULT    = 32'hFFFF_FFFF;
    localparam int             DRAIN_CYCLES_DEFAULT = 4;

    // Single-byte commands received over the UART
    localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_CONT = 8'h43;  // 'C'
    localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
    localparam logic [7:0] CMD_NEXT = 8'h4E;  // 'N'

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_WAIT_CMD = 3'd2,
        ST_RUN      = 3'd3,
        ST_STEP     = 3'd4,
        ST_DRAIN    = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

endpackage

// File: rtl/fetch_debug_ctrl_if.sv
// Bus bundle between the controller, the UART receiver, instruction memory
// and the pipeline.
//
// Handshake: i_rx_valid is a one-cycle strobe with no back-pressure; the
// controller samples i_rx_data on every cycle i_rx_valid is high, including
// back-to-back cycles. o_mem_we is likewise a one-cycle strobe qualifying
// o_mem_addr/o_mem_data. o_state is the live FSM state for observation.
`timescale 1ns/1ps
interface fetch_debug_ctrl_if;
    import fetch_debug_pkg::*;

    logic [7:0]        i_rx_data;
    logic              i_rx_valid;
    logic [LEN-1:0]    i_instruction;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [LEN-1:0]    o_mem_data;
    logic              o_pipe_en;
    logic              o_pc_hold;
    logic              o_pipe_rst_n;
    logic              o_done;
    logic [2:0]        o_state;

    // Controller side
    modport slave (
        input  i_rx_data, i_rx_valid, i_instruction,
        output o_mem_we, o_mem_addr, o_mem_data, o_pipe_en, o_pc_hold,
               o_pipe_rst_n, o_done, o_state
    );

    // Environment side (UART, fetch stage, memory)
    modport master (
        output i_rx_data, i_rx_valid, i_instruction,
        input  o_mem_we, o_mem_addr, o_mem_data, o_pipe_en, o_pc_hold,
               o_pipe_rst_n, o_done, o_state
    );

endinterface

// File: rtl/fetch_debug_ctrl_byte_word_assembler.sv
// Packs a byte stream (MSB first) into LEN-bit words. The word-valid pulse
// is combinational with the 4th byte; the caller registers it.
`timescale 1ns/1ps
module byte_word_assembler
    import fetch_debug_pkg::*;
(
    input  logic           clk_i,
    input  logic           clr_i,
    input  logic [7:0]     byte_i,
    input  logic           byte_valid_i,
    output logic           word_valid_o,
    output logic [LEN-1:0] word_o
);

    logic [1:0]     count_q, count_d;
    logic [LEN-9:0] shift_q, shift_d;

    // Shift in each accepted byte and count position within the word
    always_comb begin
        count_d = count_q;
        shift_d = shift_q;
        if (byte_valid_i) begin
            count_d = count_q + 2'd1;
            shift_d = {shift_q[LEN-17:0], byte_i};
        end
    end

    assign word_valid_o = byte_valid_i && (count_q == 2'd3);
    assign word_o       = {shift_q, byte_i};

    // Counter and partial word; clear drops any half-received word
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= 2'd0;
            shift_q <= '0;
        end else begin
            count_q <= count_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/fetch_debug_ctrl.sv
// Debug controller for the MIPS fetch stage: loads a program from the UART
// into instruction memory, then runs the pipeline continuously or one cycle
// per 'N', and drains the pipeline once the halt word is fetched.
`timescale 1ns/1ps
module fetch_debug_ctrl
    import fetch_debug_pkg::*;
#(
    parameter logic [LEN-1:0] HALT_WORD    = HALT_WORD_DEFAULT,
    parameter int             DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_rst,
    fetch_debug_ctrl_if.slave  bus
);

    localparam int                DCW       = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DCW-1:0]    drain_q, drain_d;

    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LEN-1:0]    mem_data_q, mem_data_d;
    logic              pipe_en_q, pipe_en_d;
    logic              pc_hold_q, pc_hold_d;
    logic              pipe_rst_n_q, pipe_rst_n_d;
    logic              done_q, done_d;

    logic              rx_load, rx_cont, rx_step, rx_next;
    logic              halt_hit, step_pulse;
    logic              asm_valid, asm_clr, word_valid;
    logic [LEN-1:0]    word;

    assign rx_load = bus.i_rx_valid && (bus.i_rx_data == CMD_LOAD);
    assign rx_cont = bus.i_rx_valid && (bus.i_rx_data == CMD_CONT);
    assign rx_step = bus.i_rx_valid && (bus.i_rx_data == CMD_STEP);
    assign rx_next = bus.i_rx_valid && (bus.i_rx_data == CMD_NEXT);

    // A halt only counts when the pipeline actually advanced on it
    assign halt_hit = pipe_en_q && (bus.i_instruction == HALT_WORD);

    // Only LOAD feeds bytes to the assembler; entering LOAD starts a fresh word
    assign asm_valid = bus.i_rx_valid && (state_q == ST_LOAD);
    assign asm_clr   = !i_rst || ((state_d == ST_LOAD) && (state_q != ST_LOAD));

    byte_word_assembler u_asm (
        .clk_i        (i_clk),
        .clr_i        (asm_clr),
        .byte_i       (bus.i_rx_data),
        .byte_valid_i (asm_valid),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    // Next state, counters, memory write and registered output values
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        drain_d    = drain_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        step_pulse = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_load) begin
                    state_d = ST_LOAD;
                    addr_d  = '0;
                end
            end
            ST_LOAD: begin
                if (word_valid) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = addr_q;
                    mem_data_d = word;
                    // The last address is terminal: leave LOAD rather than wrap
                    if ((word == HALT_WORD) || (addr_q == ADDR_LAST)) begin
                        state_d = ST_WAIT_CMD;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            ST_WAIT_CMD: begin
                if (rx_load) begin
                    state_d = ST_LOAD;
                    addr_d  = '0;
                end else if (rx_cont) begin
                    state_d = ST_RUN;
                end else if (rx_step) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (halt_hit) begin
                    state_d = ST_DRAIN;
                    drain_d = DCW'(DRAIN_CYCLES);
                end
            end
            ST_STEP: begin
                if (halt_hit) begin
                    state_d = ST_DRAIN;
                    drain_d = DCW'(DRAIN_CYCLES);
                end else if (rx_next) begin
                    step_pulse = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Leave on the edge where the count reaches zero so DRAIN
                // lasts exactly DRAIN_CYCLES cycles
                if (drain_q <= DCW'(1)) begin
                    state_d = ST_DONE;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q - DCW'(1);
                end
            end
            ST_DONE: begin
                if (rx_load) begin
                    state_d = ST_LOAD;
                    addr_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // RUN enables from its second cycle on; the halt transition keeps the
        // enable high straight into DRAIN so there is no bubble
        pipe_en_d    = (state_q == ST_RUN) || (state_d == ST_DRAIN) || step_pulse;
        pc_hold_d    = (state_d == ST_DRAIN);
        done_d       = (state_d == ST_DONE);
        pipe_rst_n_d = !((state_d == ST_IDLE) || (state_d == ST_LOAD));
    end

    // State, counters and all outputs are registered
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            drain_q      <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            pipe_en_q    <= 1'b0;
            pc_hold_q    <= 1'b0;
            pipe_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            drain_q      <= drain_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            pipe_en_q    <= pipe_en_d;
            pc_hold_q    <= pc_hold_d;
            pipe_rst_n_q <= pipe_rst_n_d;
            done_q       <= done_d;
        end
    end

    assign bus.o_mem_we     = mem_we_q;
    assign bus.o_mem_addr   = mem_addr_q;
    assign bus.o_mem_data   = mem_data_q;
    assign bus.o_pipe_en    = pipe_en_q;
    assign bus.o_pc_hold    = pc_hold_q;
    assign bus.o_pipe_rst_n = pipe_rst_n_q;
    assign bus.o_done       = done_q;
    assign bus.o_state      = state_q;

endmodule

// File: tb/tb_fetch_debug_ctrl.sv
// Directed bench for fetch_debug_ctrl: load, continuous run, step mode,
// address overflow, reset during load and ignored command bytes.
`timescale 1ns/1ps
module tb_fetch_debug_ctrl;
    import fetch_debug_pkg::*;

    // ---------------- clock / reset ----------------
    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    fetch_debug_ctrl_if bus();

    fetch_debug_ctrl #(
        .HALT_WORD    (32'hFFFF_FFFF),
        .DRAIN_CYCLES (4)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    int checks = 0;
    int errors = 0;

    // ---------------- scoreboard ----------------
    logic [ADDR_W+LEN-1:0] exp_q[$];
    int pe_cnt = 0;
    int ph_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every write strobe must match the head of the expected queue
    always @(negedge i_clk) begin
        logic [ADDR_W+LEN-1:0] e;
        if (bus.o_pipe_en === 1'b1) pe_cnt++;
        if (bus.o_pc_hold === 1'b1) ph_cnt++;
        if (bus.o_mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_we", bus.o_mem_we, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("wr_addr", bus.o_mem_addr, e[LEN+:ADDR_W]);
                check_eq("wr_data", bus.o_mem_data, e[LEN-1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task tick();
        @(posedge i_clk);
        #1;
    endtask

    task send_byte(input logic [7:0] b);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        tick();
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
    endtask

    task send_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) send_byte(w[k*8+:8]);
    endtask

    task expect_write(input logic [ADDR_W-1:0] a, input logic [LEN-1:0] d);
        exp_q.push_back({a, d});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base_pe;
        int base_ph;
        logic [31:0] w;

        bus.i_rx_data     = 8'h00;
        bus.i_rx_valid    = 1'b0;
        bus.i_instruction = 32'h0;
        i_rst = 1'b0;
        repeat (3) tick();
        i_rst = 1'b1;

        // Reset values
        check_eq("rst_state", bus.o_state, ST_IDLE);
        check_eq("rst_we", bus.o_mem_we, 0);
        check_eq("rst_addr", bus.o_mem_addr, 0);
        check_eq("rst_data", bus.o_mem_data, 0);
        check_eq("rst_pe", bus.o_pipe_en, 0);
        check_eq("rst_hold", bus.o_pc_hold, 0);
        check_eq("rst_prst", bus.o_pipe_rst_n, 0);
        check_eq("rst_done", bus.o_done, 0);

        // 'C' in IDLE is ignored
        send_byte(CMD_CONT);
        check_eq("idle_ign_state", bus.o_state, ST_IDLE);
        check_eq("idle_ign_pe", bus.o_pipe_en, 0);

        // Load three words, last is halt
        send_byte(CMD_LOAD);
        check_eq("load_state", bus.o_state, ST_LOAD);
        check_eq("load_prst", bus.o_pipe_rst_n, 0);
        expect_write(11'd0, 32'h0000_0001);
        expect_write(11'd1, 32'h2008_0005);
        expect_write(11'd2, HALT);
        send_word(32'h0000_0001);
        send_word(32'h2008_0005);
        send_word(HALT);
        check_eq("load_we_lat", bus.o_mem_we, 1);
        check_eq("load_end_state", bus.o_state, ST_WAIT_CMD);
        check_eq("wait_prst", bus.o_pipe_rst_n, 1);
        repeat (3) tick();
        check_eq("load_all_writes", exp_q.size(), 0);

        // 'X' in WAIT_CMD is ignored
        send_byte(8'h58);
        check_eq("wait_ign_state", bus.o_state, ST_WAIT_CMD);
        check_eq("wait_ign_pe", bus.o_pipe_en, 0);

        // Continuous run, halt seen in the 6th enabled cycle
        base_pe = pe_cnt;
        base_ph = ph_cnt;
        send_byte(CMD_CONT);
        check_eq("run_state", bus.o_state, ST_RUN);
        check_eq("run_pe_lat", bus.o_pipe_en, 0);
        tick();
        check_eq("run_pe_on", bus.o_pipe_en, 1);
        send_byte(CMD_NEXT);
        check_eq("run_ign_state", bus.o_state, ST_RUN);
        check_eq("run_ign_pe", bus.o_pipe_en, 1);
        repeat (4) tick();
        bus.i_instruction = HALT;
        tick();
        bus.i_instruction = 32'h0;
        check_eq("drain_state", bus.o_state, ST_DRAIN);
        check_eq("drain_pe", bus.o_pipe_en, 1);
        check_eq("drain_hold", bus.o_pc_hold, 1);
        repeat (3) tick();
        check_eq("drain_last_state", bus.o_state, ST_DRAIN);
        check_eq("drain_last_hold", bus.o_pc_hold, 1);
        tick();
        check_eq("done_state", bus.o_state, ST_DONE);
        check_eq("done_flag", bus.o_done, 1);
        check_eq("done_pe", bus.o_pipe_en, 0);
        check_eq("done_hold", bus.o_pc_hold, 0);
        check_eq("run_pe_total", pe_cnt - base_pe, 10);
        check_eq("run_hold_total", ph_cnt - base_ph, 4);

        // Reload a halt-only program, then step mode
        send_byte(CMD_LOAD);
        check_eq("reload_state", bus.o_state, ST_LOAD);
        check_eq("reload_done_clr", bus.o_done, 0);
        expect_write(11'd0, HALT);
        send_word(HALT);
        check_eq("reload_end_state", bus.o_state, ST_WAIT_CMD);
        tick();
        send_byte(CMD_STEP);
        check_eq("step_state", bus.o_state, ST_STEP);
        check_eq("step_pe_idle", bus.o_pipe_en, 0);
        base_pe = pe_cnt;
        for (int k = 0; k < 3; k++) begin
            send_byte(CMD_NEXT);
            check_eq("step_pulse", bus.o_pipe_en, 1);
            tick();
            check_eq("step_pulse_end", bus.o_pipe_en, 0);
            repeat (8) tick();
        end
        check_eq("step_pe_total", pe_cnt - base_pe, 3);
        check_eq("step_stay", bus.o_state, ST_STEP);

        // Halt fetched on a step drains without further 'N'
        send_byte(CMD_NEXT);
        bus.i_instruction = HALT;
        tick();
        bus.i_instruction = 32'h0;
        check_eq("step_drain_state", bus.o_state, ST_DRAIN);
        check_eq("step_drain_pe", bus.o_pipe_en, 1);
        check_eq("step_drain_hold", bus.o_pc_hold, 1);
        repeat (4) tick();
        check_eq("step_done_state", bus.o_state, ST_DONE);
        check_eq("step_done_pe", bus.o_pipe_en, 0);
        check_eq("step_done_flag", bus.o_done, 1);

        // Reset after two bytes of a word; the partial word must vanish
        send_byte(CMD_LOAD);
        send_byte(8'hAA);
        send_byte(8'hBB);
        i_rst = 1'b0;
        tick();
        check_eq("midrst_state", bus.o_state, ST_IDLE);
        check_eq("midrst_prst", bus.o_pipe_rst_n, 0);
        check_eq("midrst_done", bus.o_done, 0);
        i_rst = 1'b1;
        send_byte(CMD_LOAD);
        expect_write(11'd0, 32'h1122_3344);
        send_word(32'h1122_3344);
        repeat (2) tick();
        check_eq("midrst_writes", exp_q.size(), 0);
        check_eq("midrst_load", bus.o_state, ST_LOAD);

        // Fill every address; the last address ends LOAD
        i_rst = 1'b0;
        tick();
        i_rst = 1'b1;
        send_byte(CMD_LOAD);
        for (int i = 0; i < 2048; i++) begin
            w = 32'(i);
            expect_write(w[ADDR_W-1:0], w);
            send_word(w);
        end
        check_eq("ovf_state", bus.o_state, ST_WAIT_CMD);
        check_eq("ovf_last_addr", bus.o_mem_addr, 2047);
        repeat (2) tick();
        check_eq("ovf_writes", exp_q.size(), 0);
        send_word(32'h0102_0304);
        repeat (3) tick();
        check_eq("ovf_extra_state", bus.o_state, ST_WAIT_CMD);
        check_eq("ovf_extra_addr", bus.o_mem_addr, 2047);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
